// File: rtl/prio_intr_if.sv
// Register-port and interrupt-handshake signals between the uP (master) and
// the priority interrupt controller (slave).
interface prio_intr_if #(
    parameter int ID_W       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  wr_en_i;
    logic                  rd_en_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  intr_valid_o;
    logic [ID_W-1:0]       intr_id_o;
    logic                  intr_ack_i;
    logic                  in_service_o;
    logic                  intr_serviced_i;

    modport master (
        output addr_i, wr_data_i, wr_en_i, rd_en_i, valid_i, intr_ack_i, intr_serviced_i,
        input  ready_o, rd_data_o, rd_valid_o, intr_valid_o, intr_id_o, in_service_o
    );

    modport slave (
        input  addr_i, wr_data_i, wr_en_i, rd_en_i, valid_i, intr_ack_i, intr_serviced_i,
        output ready_o, rd_data_o, rd_valid_o, intr_valid_o, intr_id_o, in_service_o
    );
endinterface

// File: rtl/prio_intr_ctrl.sv
// Maskable, priority-programmable interrupt controller: per-source edge/level
// capture, max-priority arbitration with pre-emption, ack/service handshake.

module prio_intr_src (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic intr_i,
    input  logic mode_i,
    input  logic w1c_i,
    input  logic svc_clr_i,
    output logic pend_o
);
    logic intr_q, intr_q_d, edge_pend_q;

    // A fresh rising edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            intr_q      <= 1'b0;
            intr_q_d    <= 1'b0;
            edge_pend_q <= 1'b0;
        end else begin
            intr_q      <= intr_i;
            intr_q_d    <= intr_q;
            edge_pend_q <= mode_i & ((edge_pend_q & ~w1c_i & ~svc_clr_i) | (intr_q & ~intr_q_d));
        end
    end

    assign pend_o = mode_i ? edge_pend_q : intr_q;
endmodule

module prio_intr_ctrl #(
    parameter int NUM_INTR   = 16,
    parameter int PRIO_W     = 4,
    parameter int ID_W       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NUM_INTR-1:0] intr_i,
    prio_intr_if.slave          bus
);
    localparam logic [ADDR_WIDTH-1:0] ENA_A  = ADDR_WIDTH'(NUM_INTR);
    localparam logic [ADDR_WIDTH-1:0] MODE_A = ADDR_WIDTH'(NUM_INTR + 1);
    localparam logic [ADDR_WIDTH-1:0] PEND_A = ADDR_WIDTH'(NUM_INTR + 2);

    typedef enum logic [1:0] {IDLE, ARB, PEND, SERV} state_t;

    logic [NUM_INTR-1:0][PRIO_W-1:0] prio_q;
    logic [NUM_INTR-1:0]             enable_q, mode_q, pend, elig, w1c, svc_clr;
    logic                            ready_q, rd_valid_q, intr_valid_q, in_service_q;
    logic [DATA_WIDTH-1:0]           rd_data_q, rd_mux;
    logic [ID_W-1:0]                 id_q, win_id;
    logic [PRIO_W-1:0]               win_prio;
    logic                            win_vld, wr_xfer, rd_xfer, preempt;
    state_t                          state_q;

    assign wr_xfer = bus.valid_i & ready_q & bus.wr_en_i;
    assign rd_xfer = bus.valid_i & ready_q & ~bus.wr_en_i & bus.rd_en_i;
    assign w1c     = (wr_xfer && bus.addr_i == PEND_A) ? bus.wr_data_i[NUM_INTR-1:0] : '0;

    always_comb begin
        svc_clr = '0;
        if (state_q == SERV && bus.intr_serviced_i) svc_clr[id_q] = 1'b1;
    end

    for (genvar g = 0; g < NUM_INTR; g++) begin : g_src
        prio_intr_src u_src (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .intr_i    (intr_i[g]),
            .mode_i    (mode_q[g]),
            .w1c_i     (w1c[g]),
            .svc_clr_i (svc_clr[g]),
            .pend_o    (pend[g])
        );
    end

    assign elig = pend & enable_q;

    // Ascending scan with strict '>' leaves ties on the lowest index.
    always_comb begin
        win_vld  = 1'b0;
        win_prio = '0;
        win_id   = '0;
        for (int k = 0; k < NUM_INTR; k++) begin
            if (elig[k] && (!win_vld || prio_q[k] > win_prio)) begin
                win_vld  = 1'b1;
                win_prio = prio_q[k];
                win_id   = ID_W'(k);
            end
        end
    end

    assign preempt = win_vld && (win_prio > prio_q[id_q]);

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_INTR; k++)
            if (bus.addr_i == ADDR_WIDTH'(k)) rd_mux[PRIO_W-1:0] = prio_q[k];
        if (bus.addr_i == ENA_A)  rd_mux[NUM_INTR-1:0] = enable_q;
        if (bus.addr_i == MODE_A) rd_mux[NUM_INTR-1:0] = mode_q;
        if (bus.addr_i == PEND_A) rd_mux[NUM_INTR-1:0] = pend;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prio_q     <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            ready_q    <= 1'b1;
            rd_valid_q <= rd_xfer;
            if (rd_xfer) rd_data_q <= rd_mux;
            if (wr_xfer) begin
                for (int k = 0; k < NUM_INTR; k++)
                    if (bus.addr_i == ADDR_WIDTH'(k)) prio_q[k] <= bus.wr_data_i[PRIO_W-1:0];
                if (bus.addr_i == ENA_A)  enable_q <= bus.wr_data_i[NUM_INTR-1:0];
                if (bus.addr_i == MODE_A) mode_q   <= bus.wr_data_i[NUM_INTR-1:0];
            end
        end
    end

    // Ack is checked before pre-emption so an acked id is the one serviced.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            intr_valid_q <= 1'b0;
            in_service_q <= 1'b0;
            id_q         <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (win_vld) state_q <= ARB;
                ARB: begin
                    if (win_vld) begin
                        id_q         <= win_id;
                        intr_valid_q <= 1'b1;
                        state_q      <= PEND;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PEND: begin
                    if (bus.intr_ack_i) begin
                        intr_valid_q <= 1'b0;
                        in_service_q <= 1'b1;
                        state_q      <= SERV;
                    end else if (preempt) begin
                        id_q <= win_id;
                    end else if (!elig[id_q]) begin
                        intr_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                SERV: begin
                    if (bus.intr_serviced_i) begin
                        in_service_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_o      = ready_q;
    assign bus.rd_data_o    = rd_data_q;
    assign bus.rd_valid_o   = rd_valid_q;
    assign bus.intr_valid_o = intr_valid_q;
    assign bus.intr_id_o    = id_q;
    assign bus.in_service_o = in_service_q;
endmodule

// File: tb/tb_prio_intr_ctrl.sv
// Bench for prio_intr_ctrl: register table with a read scoreboard, plus
// hand-written interrupt handshake sequences.
module tb_prio_intr_ctrl;
    localparam logic [4:0] ENA_A = 5'd16, MODE_A = 5'd17, PEND_A = 5'd18;

    logic        clk, rst_n;
    logic [15:0] intr;
    int          total = 0, bad = 0;

    typedef struct {string nm; logic [15:0] exp;} rd_exp_t;
    typedef struct {logic [4:0] addr; logic [15:0] wdata; logic [15:0] exp;} vec_t;
    rd_exp_t exp_q[$];
    vec_t    vecs[6];

    prio_intr_if bus ();

    prio_intr_ctrl dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .intr_i  (intr),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rd_valid_o) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                chk(e.nm, bus.rd_data_o, e.exp);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        bus.addr_i = a; bus.wr_data_i = d; bus.wr_en_i = 1'b1; bus.valid_i = 1'b1;
        tick;
        bus.wr_en_i = 1'b0; bus.valid_i = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [4:0] a, input logic [15:0] e);
        rd_exp_t r;
        r.nm = nm; r.exp = e;
        exp_q.push_back(r);
        bus.addr_i = a; bus.rd_en_i = 1'b1; bus.valid_i = 1'b1;
        tick;
        bus.rd_en_i = 1'b0; bus.valid_i = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] m);
        intr = m;
        tick;
        intr = '0;
    endtask

    task automatic wait_valid(input string nm, output int cyc);
        cyc = 0;
        while (!bus.intr_valid_o && cyc < 30) begin
            tick;
            cyc++;
        end
        if (!bus.intr_valid_o) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic ack;
        bus.intr_ack_i = 1'b1;
        tick;
        bus.intr_ack_i = 1'b0;
    endtask

    task automatic serve;
        bus.intr_serviced_i = 1'b1;
        tick;
        bus.intr_serviced_i = 1'b0;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{5'd0,  16'hFFF5, 16'h0005};
        vecs[1] = '{5'd15, 16'h000A, 16'h000A};
        vecs[2] = '{ENA_A, 16'hA5A5, 16'hA5A5};
        vecs[3] = '{MODE_A, 16'h1234, 16'h1234};
        vecs[4] = '{5'd20, 16'hBEEF, 16'h0000};
        vecs[5] = '{5'd31, 16'h1111, 16'h0000};

        rst_n = 1'b0; intr = '0;
        bus.addr_i = '0; bus.wr_data_i = '0; bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0;
        bus.valid_i = 1'b0; bus.intr_ack_i = 1'b0; bus.intr_serviced_i = 1'b0;
        #12;
        chk("rst_ready", bus.ready_o, 0);
        chk("rst_valid", bus.intr_valid_o, 0);
        chk("rst_id", bus.intr_id_o, 0);
        chk("rst_insvc", bus.in_service_o, 0);
        chk("rst_rdvalid", bus.rd_valid_o, 0);
        chk("rst_rddata", bus.rd_data_o, 0);
        @(negedge clk) rst_n = 1'b1;
        tick;
        chk("ready_after_rst", bus.ready_o, 1);
        rd("rst_enable", ENA_A, 16'h0000);

        // register table
        for (int i = 0; i < 6; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // edge mode, PRIO[k] = k
        for (int k = 0; k < 16; k++) wr(5'(k), 16'(k));
        wr(ENA_A, 16'hFFFF);
        wr(MODE_A, 16'hFFFF);
        pulse(16'h0024);
        wait_valid("edge_first", cyc);
        chk("edge_latency", cyc, 3);
        chk("edge_id5", bus.intr_id_o, 5);
        ack;
        chk("ack_valid_low", bus.intr_valid_o, 0);
        chk("ack_insvc", bus.in_service_o, 1);
        chk("ack_id_held", bus.intr_id_o, 5);
        serve;
        chk("svc_insvc_low", bus.in_service_o, 0);
        wait_valid("edge_second", cyc);
        chk("edge_id2", bus.intr_id_o, 2);
        ack;
        serve;
        repeat (5) tick;
        chk("edge_idle", bus.intr_valid_o, 0);
        rd("edge_pend_clear", PEND_A, 16'h0000);

        // tie and mask
        for (int k = 0; k < 16; k++) wr(5'(k), 16'd3);
        wr(ENA_A, 16'hFFF7);
        pulse(16'h0018);
        wait_valid("tie", cyc);
        chk("tie_id4", bus.intr_id_o, 4);
        rd("tie_pending", PEND_A, 16'h0018);
        ack;
        serve;
        wr(PEND_A, 16'hFFFF);
        rd("w1c_all", PEND_A, 16'h0000);

        // pre-emption before ack, none after
        wr(5'd1, 16'd2);
        wr(5'd9, 16'd7);
        wr(ENA_A, 16'hFFFF);
        pulse(16'h0002);
        wait_valid("pre_src1", cyc);
        chk("pre_id1", bus.intr_id_o, 1);
        pulse(16'h0200);
        tick;
        chk("pre_id_still1", bus.intr_id_o, 1);
        tick;
        chk("pre_id9", bus.intr_id_o, 9);
        chk("pre_valid_kept", bus.intr_valid_o, 1);
        ack;
        serve;
        wait_valid("pre_back1", cyc);
        chk("pre_back_id1", bus.intr_id_o, 1);
        ack;
        pulse(16'h0200);
        repeat (4) tick;
        chk("serv_no_preempt_id", bus.intr_id_o, 1);
        chk("serv_no_preempt_insvc", bus.in_service_o, 1);
        chk("serv_no_preempt_valid", bus.intr_valid_o, 0);
        serve;
        wait_valid("post_serv9", cyc);
        chk("post_serv_id9", bus.intr_id_o, 9);
        ack;
        serve;

        // level mode
        wr(MODE_A, 16'h0000);
        intr = 16'h0040;
        wait_valid("lvl", cyc);
        chk("lvl_id6", bus.intr_id_o, 6);
        ack;
        serve;
        chk("lvl_svc_valid", bus.intr_valid_o, 0);
        tick;
        chk("lvl_arb_valid", bus.intr_valid_o, 0);
        tick;
        chk("lvl_repres_valid", bus.intr_valid_o, 1);
        chk("lvl_repres_id", bus.intr_id_o, 6);
        intr = '0;
        tick;
        chk("lvl_drop_valid_hold", bus.intr_valid_o, 1);
        tick;
        chk("lvl_drop_valid_low", bus.intr_valid_o, 0);
        repeat (3) tick;
        chk("lvl_idle", bus.intr_valid_o, 0);

        // W1C racing a new edge
        wr(MODE_A, 16'hFFFF);
        wr(ENA_A, 16'h0000);
        intr = 16'h0001;
        tick;
        wr(PEND_A, 16'h0001);
        rd("race_set_wins", PEND_A, 16'h0001);
        wr(PEND_A, 16'h0001);
        rd("w1c_clears", PEND_A, 16'h0000);
        intr = '0;

        // reset mid-PEND
        wr(ENA_A, 16'hFFFF);
        pulse(16'h0008);
        wait_valid("mid_rst", cyc);
        chk("mid_rst_id3", bus.intr_id_o, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.intr_valid_o, 0);
        chk("mid_rst_id", bus.intr_id_o, 0);
        chk("mid_rst_ready", bus.ready_o, 0);
        chk("mid_rst_insvc", bus.in_service_o, 0);
        @(negedge clk) rst_n = 1'b1;
        tick;
        chk("mid_rst_ready_back", bus.ready_o, 1);
        rd("mid_rst_enable", ENA_A, 16'h0000);
        repeat (3) tick;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
